// File: rtl/vram_arbiter.sv
// VRAM port arbiter: scanout reads own the bus with zero wait; the Z80 gets the
// idle cycles through a four-phase req/ack handshake and a saturating stall counter.
module vram_arbiter #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vid_req,
  input  logic [ADDR_W-1:0]  vid_addr,
  output logic [7:0]         vid_data,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ack,
  output logic               cpu_wait,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  output logic [STALL_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               wr_q, wr_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               grant_c;

  // State register; reset abandons any in-flight transfer without an ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= 8'h00;
      wr_q    <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      stall_q <= stall_d;
    end
  end

  // Next state, capture and bus steering
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    wr_d      = wr_q;
    stall_d   = stall_q;
    grant_c   = 1'b0;
    mem_addr  = cpu_addr;
    mem_we    = 1'b0;
    mem_wdata = cpu_wdata;

    unique case (state_q)
      IDLE: begin
        if (!reset && cpu_req) begin
          if (vid_req) begin
            if (stall_q != {STALL_W{1'b1}}) stall_d = stall_q + STALL_W'(1);
          end else begin
            grant_c = 1'b1;
            wr_d    = cpu_we;
            state_d = CAPT;
          end
        end
      end
      CAPT: begin
        // Read data from the grant cycle arrives now; the direction is latched
        // so a misbehaving CPU dropping its strobes cannot corrupt the capture
        if (!wr_q) rdata_d = mem_rdata;
        state_d = ACK;
      end
      ACK: begin
        if (!cpu_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (vid_req) begin
      mem_addr = vid_addr;
    end else if (grant_c) begin
      mem_we = cpu_we;
    end
  end

  assign vid_data    = mem_rdata;
  assign cpu_rdata   = rdata_q;
  assign cpu_ack     = (state_q == ACK);
  assign cpu_wait    = cpu_req & ~cpu_ack;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM and a
// read-data scoreboard popped on each cpu_ack.
module tb_vram_arbiter;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned STALL_W = 4;

  logic               clk;
  logic               reset;
  logic               vid_req;
  logic [ADDR_W-1:0]  vid_addr;
  logic [7:0]         vid_data;
  logic               cpu_req;
  logic               cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [7:0]         cpu_wdata;
  logic [7:0]         cpu_rdata;
  logic               cpu_ack;
  logic               cpu_wait;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_we;
  logic [7:0]         mem_wdata;
  logic [7:0]         mem_rdata;
  logic [STALL_W-1:0] stall_count;

  logic [7:0] ram [0:(1 << ADDR_W) - 1];
  logic [7:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;
  int         we_cnt = 0;
  int         we0;

  vram_arbiter #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_wait   (cpu_wait),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, one-cycle read latency, read-before-write
  always @(posedge clk) begin
    if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=ack expected=no pending read", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(cpu_rdata), 32'(e));
    end
  endtask

  // Raise a write and wait, bounded, for its ack; then complete the handshake
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    int n;
    n = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1;
    while (cpu_ack !== 1'b1 && n < 50) begin
      tick(); #1; n++;
    end
    chk("wr_ack_seen", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
  endtask

  // Uncontended read: grant now, ack exactly two cycles later
  task automatic read_exact(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] e);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    exp_q.push_back(e);
    #1;
    chk({tag, "_grant_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_grant_we"}, 32'(mem_we), 32'd0);
    tick(); #1;
    chk({tag, "_ack_t1"}, 32'(cpu_ack), 32'd0);
    tick(); #1;
    chk({tag, "_ack_t2"}, 32'(cpu_ack), 32'd1);
    chk({tag, "_wait_t2"}, 32'(cpu_wait), 32'd0);
    pop_check({tag, "_data"});
    cpu_req = 1'b0;
    tick(); #1;
    chk({tag, "_ack_drop"}, 32'(cpu_ack), 32'd0);
  endtask

  initial begin
    reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = 8'hFF;
    tick(); tick(); #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Write 0xAA to 0x0000, then scan it back
    we0 = we_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0000; cpu_wdata = 8'hAA;
    #1;
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h0000);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hAA);
    tick(); #1;
    chk("wr_we_capt", 32'(mem_we), 32'd0);
    tick(); #1;
    chk("wr_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    vid_req = 1'b1; vid_addr = 13'h0000;
    #1;
    chk("scan_addr", 32'(mem_addr), 32'h0000);
    chk("scan_we", 32'(mem_we), 32'd0);
    tick();
    vid_req = 1'b0;
    #1;
    chk("scan_data", 32'(vid_data), 32'hAA);
    chk("wr_ack_drop", 32'(cpu_ack), 32'd0);
    chk("wr_we_once", 32'(we_cnt - we0), 32'd1);

    do_write(13'h1800, 8'h47);
    do_write(13'h0123, 8'h5C);

    read_exact("rd1800", 13'h1800, 8'h47);
    chk("rd_stall", 32'(stall_count), 32'd0);

    // Contention: scanout and CPU rise together, scanout held four cycles
    exp_q.push_back(8'h5C);
    for (int c = 0; c < 7; c++) begin
      vid_req = (c < 4); vid_addr = 13'h0400;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
      #1;
      chk("cont_wait", 32'(cpu_wait), 32'(c <= 5));
      chk("cont_ack", 32'(cpu_ack), 32'(c == 6));
      if (c < 4) chk("cont_vid_own", 32'(mem_addr), 32'h0400);
      if (c == 4) chk("cont_grant", 32'(mem_addr), 32'h0123);
      if (c == 6) begin
        pop_check("cont_data");
        chk("cont_stall", 32'(stall_count), 32'd4);
      end
      if (c < 6) tick();
    end

    // Hold the request after ack: no re-grant, ack held
    we0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("hold_ack", 32'(cpu_ack), 32'd1);
      chk("hold_no_we", 32'(mem_we), 32'd0);
      chk("hold_stall", 32'(stall_count), 32'd4);
    end
    chk("hold_rdata", 32'(cpu_rdata), 32'h5C);
    cpu_req = 1'b0;
    tick(); #1;
    chk("hold_ack_drop", 32'(cpu_ack), 32'd0);
    chk("hold_we_none", 32'(we_cnt - we0), 32'd0);
    read_exact("rd_after_hold", 13'h0000, 8'hAA);

    // Reset while the read sits in CAPT
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1800;
    tick();
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_ack", 32'(cpu_ack), 32'd0);
    chk("abort_rdata", 32'(cpu_rdata), 32'h00);
    chk("abort_stall", 32'(stall_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("abort_no_ack", 32'(cpu_ack), 32'd0);
    end
    read_exact("rd_after_abort", 13'h1800, 8'h47);

    // Saturation of the 4-bit stall counter
    exp_q.push_back(8'hAA);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0000;
    vid_req = 1'b1; vid_addr = 13'h0123;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("sat_count", 32'(stall_count), (i < 15) ? 32'(i) : 32'd15);
      chk("sat_wait", 32'(cpu_wait), 32'd1);
      tick();
    end
    vid_req = 1'b0;
    #1;
    chk("sat_final", 32'(stall_count), 32'd15);
    chk("sat_grant", 32'(mem_addr), 32'h0000);
    tick(); tick(); #1;
    chk("sat_ack", 32'(cpu_ack), 32'd1);
    pop_check("sat_data");
    chk("sat_hold", 32'(stall_count), 32'd15);
    cpu_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port 8 KB video RAM between the raster scanout engine and the Z80 CPU. Scanout reads have absolute priority and zero wait. The CPU gets every cycle the scanout leaves idle, through a four-phase request/acknowledge handshake, plus a WAIT output for the Z80 bus. The block sits between the video generator, the CPU bus decoder and the synchronous VRAM. It also counts CPU contention cycles for debug.

## Interface

Parameters:
- ADDR_W, 13: VRAM address width (8 KB).
- STALL_W, 16: width of the saturating contention counter.

Ports:
- clk  in  1: pixel clock, 25 MHz; all logic on rising edge.
- reset  in  1: synchronous, active-high reset.
- vid_req  in  1: scanout read strobe, one cycle per fetch.
- vid_addr  in  ADDR_W: scanout read address, valid with vid_req.
- vid_data  out  8: scanout read data; equals mem_rdata, valid the cycle after vid_req.
- cpu_req  in  1: CPU access request; level, held until cpu_ack.
- cpu_we  in  1: 1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W: CPU address; stable while cpu_req is high.
- cpu_wdata  in  8: CPU write data; stable while cpu_req is high.
- cpu_rdata  out  8: registered read data, valid while cpu_ack is high.
- cpu_ack  out  1: access complete; high until cpu_req falls.
- cpu_wait  out  1: cpu_req & ~cpu_ack, driven to the Z80 WAIT logic.
- mem_addr  out  ADDR_W: VRAM address.
- mem_we  out  1: VRAM write enable.
- mem_wdata  out  8: VRAM write data.
- mem_rdata  in  8: VRAM read data, one-cycle latency.
- stall_count  out  STALL_W: number of cycles the CPU was blocked by the scanout.

## Operation

- FSM states: IDLE, CAPT, ACK.
- IDLE:
  - If cpu_req & ~vid_req, grant the CPU this cycle: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata. Next state CAPT.
  - If cpu_req & vid_req, the scanout owns the bus. Stay in IDLE and increment stall_count.
- CAPT: cpu_rdata <= mem_rdata, for reads only; writes leave cpu_rdata unchanged. Next state ACK.
- ACK: cpu_ack=1. Return to IDLE in the first cycle cpu_req is seen low.
- Scanout ownership: whenever vid_req=1, mem_addr=vid_addr and mem_we=0, in any state.
  - A vid_req in CAPT or ACK does not disturb the CPU transfer, because the CPU access already issued in its grant cycle.
- Bus default: with no grant and no vid_req, mem_addr=cpu_addr and mem_we=0.
- mem_we is high only in a CPU write grant cycle, for exactly one cycle per transaction.
- stall_count saturates at 2^STALL_W-1 and never wraps.
- A request is never granted twice. A new transaction requires cpu_req to fall and rise again.

## Timing

- Reset values: state IDLE, cpu_ack=0, cpu_rdata=0x00, stall_count=0, mem_we=0.
- Uncontended latency: grant at cycle t, cpu_ack high from cycle t+2. Read and write latency are identical.
- A CPU write is visible to a scanout read issued at t+1 or later.
- Contended latency: each cycle with vid_req=1 while in IDLE with cpu_req=1 adds one cycle and one stall count.
- Simultaneous vid_req and cpu_req rising in the same cycle: the scanout wins, and the CPU is granted in the first later cycle with vid_req=0.
- Reset mid-transaction:
  - A write grant cycle already completed stands in RAM.
  - No cpu_ack is generated for an aborted transaction.
  - The CPU must re-request.
- cpu_req dropped before cpu_ack is a protocol violation; the FSM still completes to ACK and then returns to IDLE.

## Test plan

- Uncontended read: RAM[0x1800]=0x47, cpu_req at cycle 0 with vid_req idle -> mem_addr=0x1800 at cycle 0, cpu_ack=1 at cycle 2, cpu_rdata=0x47, stall_count=0.
- Write then scan: CPU writes 0xAA to 0x0000 -> mem_we high for exactly one cycle. A following vid_req at 0x0000 -> vid_data=0xAA the next cycle.
- Contention: vid_req held cycles 0..3, cpu_req rising at cycle 0 -> CPU grant at cycle 4, cpu_ack at cycle 6, stall_count=4, cpu_wait high cycles 0..5.
- Handshake: hold cpu_req 5 cycles after cpu_ack -> cpu_ack stays high, no second mem access. After cpu_req falls -> cpu_ack low next cycle, FSM in IDLE.
- Reset in CAPT during a read -> cpu_ack never asserts, cpu_rdata=0x00, stall_count=0, next request completes normally.
- Saturation with STALL_W=4: vid_req held 20 cycles with cpu_req pending -> stall_count stops at 15.
